// File: rtl/jump_executor.sv
// -----------------------------------------------------------------------------
// jump_executor
//
// Consumer end of the jump-window interface. A rising edge on the debounced
// jump button is latched. When the window generator opens a window (can_jump),
// the block runs a rise / hold / fall trajectory and drives the vertical pixel
// offset used by the sprite renderer. A request that sees no window within
// REQ_TIMEOUT cycles is dropped.
//
// Optional feature (compile-time macro JUMP_BUFFER_EN):
//   A press during FALL is remembered in a one-bit buffer. On landing, the
//   block goes to PENDING instead of IDLE, or goes straight into a new RISE
//   when a window is open on the landing cycle. In that case jump_done and
//   jump_start pulse together.
//
// Ports:
//   proc_clk    in   processor clock, all logic on the rising edge
//   reset       in   synchronous active-high reset
//   can_jump    in   jump-window strobe from the window generator
//   jump_btn    in   debounced jump button (level)
//   y_offset    out  current upward displacement in pixels
//   jumping     out  high while in RISE, HOLD or FALL
//   busy        out  high in any state except IDLE
//   jump_start  out  one-cycle pulse on entry to RISE
//   jump_done   out  one-cycle pulse on landing (FALL -> not FALL)
//   req_dropped out  one-cycle pulse when a pending request times out
// -----------------------------------------------------------------------------
module jump_executor #(
    parameter int STEP        = 4,
    parameter int RISE_CYCLES = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int REQ_TIMEOUT = 16,
    parameter int OFFSET_W    = 10
) (
    input  logic                proc_clk,
    input  logic                reset,
    input  logic                can_jump,
    input  logic                jump_btn,
    output logic [OFFSET_W-1:0] y_offset,
    output logic                jumping,
    output logic                busy,
    output logic                jump_start,
    output logic                jump_done,
    output logic                req_dropped
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        RISE    = 3'd2,
        HOLD    = 3'd3,
        FALL    = 3'd4
    } state_t;

    // One counter is shared by RISE and HOLD, so size it for the longer phase.
    localparam int PHASE_MAX = (RISE_CYCLES > HOLD_CYCLES) ? RISE_CYCLES : HOLD_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int WAIT_W    = $clog2(REQ_TIMEOUT + 1);

    localparam logic [OFFSET_W:0]   STEP_EXT   = (OFFSET_W + 1)'(STEP);
    localparam logic [OFFSET_W-1:0] OFFSET_MAX = {OFFSET_W{1'b1}};
    localparam logic [PHASE_W-1:0]  RISE_LAST  = PHASE_W'(RISE_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  HOLD_LAST  = PHASE_W'(HOLD_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(REQ_TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic [OFFSET_W-1:0] y_reg, y_next;
    logic [PHASE_W-1:0]  phase_reg, phase_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic                btn_q_reg;
    logic                start_reg, start_next;
    logic                done_reg, done_next;
    logic                dropped_reg, dropped_next;
    logic                jumping_reg, jumping_next;
    logic                busy_reg, busy_next;
`ifdef JUMP_BUFFER_EN
    logic                buf_reg, buf_next;
`endif

    logic                press;
    logic [OFFSET_W:0]   y_sum;

    assign press = jump_btn & ~btn_q_reg;
    // One extra bit catches the carry so the rise can saturate.
    assign y_sum = {1'b0, y_reg} + STEP_EXT;

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            y_reg       <= '0;
            phase_reg   <= '0;
            wait_reg    <= '0;
            btn_q_reg   <= 1'b0;
            start_reg   <= 1'b0;
            done_reg    <= 1'b0;
            dropped_reg <= 1'b0;
            jumping_reg <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef JUMP_BUFFER_EN
            buf_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            y_reg       <= y_next;
            phase_reg   <= phase_next;
            wait_reg    <= wait_next;
            btn_q_reg   <= jump_btn;
            start_reg   <= start_next;
            done_reg    <= done_next;
            dropped_reg <= dropped_next;
            jumping_reg <= jumping_next;
            busy_reg    <= busy_next;
`ifdef JUMP_BUFFER_EN
            buf_reg     <= buf_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        y_next       = y_reg;
        phase_next   = phase_reg;
        wait_next    = wait_reg;
        start_next   = 1'b0;
        done_next    = 1'b0;
        dropped_next = 1'b0;
`ifdef JUMP_BUFFER_EN
        buf_next     = buf_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (press) begin
                    if (can_jump) begin
                        state_next = RISE;
                        phase_next = '0;
                        start_next = 1'b1;
                    end else begin
                        state_next = PENDING;
                        wait_next  = '0;
                    end
                end
            end

            PENDING: begin
                // An open window wins over a timeout in the same cycle.
                if (can_jump) begin
                    state_next = RISE;
                    phase_next = '0;
                    start_next = 1'b1;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next   = IDLE;
                    dropped_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end

            RISE: begin
                y_next = y_sum[OFFSET_W] ? OFFSET_MAX : y_sum[OFFSET_W-1:0];
                if (phase_reg == RISE_LAST) begin
                    state_next = HOLD;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end

            HOLD: begin
                if (phase_reg == HOLD_LAST) begin
                    state_next = FALL;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end

            FALL: begin
                if ({1'b0, y_reg} > STEP_EXT) begin
                    y_next = y_reg - STEP_EXT[OFFSET_W-1:0];
`ifdef JUMP_BUFFER_EN
                    if (press) begin
                        buf_next = 1'b1;
                    end
`endif
                end else begin
                    y_next     = '0;
                    done_next  = 1'b1;
                    state_next = IDLE;
`ifdef JUMP_BUFFER_EN
                    // A press on the landing cycle itself counts as buffered.
                    if (buf_reg | press) begin
                        buf_next = 1'b0;
                        if (can_jump) begin
                            state_next = RISE;
                            phase_next = '0;
                            start_next = 1'b1;
                        end else begin
                            state_next = PENDING;
                            wait_next  = '0;
                        end
                    end
`endif
                end
            end

            default: begin
                state_next = IDLE;
                y_next     = '0;
            end
        endcase

        jumping_next = (state_next == RISE) || (state_next == HOLD) || (state_next == FALL);
        busy_next    = (state_next != IDLE);
    end

    assign y_offset    = y_reg;
    assign jumping     = jumping_reg;
    assign busy        = busy_reg;
    assign jump_start  = start_reg;
    assign jump_done   = done_reg;
    assign req_dropped = dropped_reg;

endmodule

// File: tb/tb_jump_executor.sv
// -----------------------------------------------------------------------------
// tb_jump_executor
//
// Self-checking bench for jump_executor with default parameters. The reference
// model describes a jump as a precomputed table of y_offset values, one entry
// per cycle of flight, plus a pending-request timer. Directed scenarios follow
// the timing of the jump trajectory; a randomized phase follows them.
// Define JUMP_BUFFER_EN for both files to exercise the buffered-press feature.
// -----------------------------------------------------------------------------
module tb_jump_executor;

    localparam int STEP        = 4;
    localparam int RISE_CYCLES = 8;
    localparam int HOLD_CYCLES = 4;
    localparam int REQ_TIMEOUT = 16;
    localparam int OFFSET_W    = 10;

    logic                proc_clk;
    logic                reset;
    logic                can_jump;
    logic                jump_btn;
    logic [OFFSET_W-1:0] y_offset;
    logic                jumping;
    logic                busy;
    logic                jump_start;
    logic                jump_done;
    logic                req_dropped;

    jump_executor #(
        .STEP        (STEP),
        .RISE_CYCLES (RISE_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .REQ_TIMEOUT (REQ_TIMEOUT),
        .OFFSET_W    (OFFSET_W)
    ) dut (
        .proc_clk    (proc_clk),
        .reset       (reset),
        .can_jump    (can_jump),
        .jump_btn    (jump_btn),
        .y_offset    (y_offset),
        .jumping     (jumping),
        .busy        (busy),
        .jump_start  (jump_start),
        .jump_done   (jump_done),
        .req_dropped (req_dropped)
    );

    initial begin
        proc_clk = 1'b0;
        forever #5 proc_clk = ~proc_clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: trajectory table and abstract bookkeeping.
    int traj[$];
    int m_pos;      // index into traj while airborne, -1 otherwise
    int m_wait;     // cycles a request has been pending, -1 when none
    int m_prev;
    int m_buf;
    int m_start, m_done, m_drop;

    function automatic void build_traj();
        int y;
        traj.delete();
        for (int i = 0; i <= RISE_CYCLES; i++) traj.push_back(i * STEP);
        for (int i = 0; i < HOLD_CYCLES; i++) traj.push_back(RISE_CYCLES * STEP);
        y = RISE_CYCLES * STEP;
        while (y > STEP) begin
            y = y - STEP;
            traj.push_back(y);
        end
    endfunction

    function automatic void model_step(input logic r, input logic c, input logic b);
        int press;
        m_start = 0;
        m_done  = 0;
        m_drop  = 0;
        if (r) begin
            m_pos  = -1;
            m_wait = -1;
            m_prev = 0;
            m_buf  = 0;
            return;
        end
        press  = (b && !m_prev) ? 1 : 0;
        m_prev = b ? 1 : 0;
        if (m_pos >= 0) begin
            if (m_pos == traj.size() - 1) begin
                m_pos  = -1;
                m_done = 1;
`ifdef JUMP_BUFFER_EN
                if (m_buf == 1 || press == 1) begin
                    m_buf = 0;
                    if (c) begin
                        m_pos   = 0;
                        m_start = 1;
                    end else begin
                        m_wait = 0;
                    end
                end
`endif
            end else begin
`ifdef JUMP_BUFFER_EN
                // Entries from RISE_CYCLES+HOLD_CYCLES onward are spent falling.
                if (m_pos >= RISE_CYCLES + HOLD_CYCLES && press == 1) m_buf = 1;
`endif
                m_pos++;
            end
        end else if (m_wait >= 0) begin
            if (c) begin
                m_wait  = -1;
                m_pos   = 0;
                m_start = 1;
            end else if (m_wait == REQ_TIMEOUT - 1) begin
                m_wait = -1;
                m_drop = 1;
            end else begin
                m_wait++;
            end
        end else if (press == 1) begin
            if (c) begin
                m_pos   = 0;
                m_start = 1;
            end else begin
                m_wait = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, step the model on the rising
    // edge, compare every output 1 time unit later.
    task automatic cycle(input logic r, input logic c, input logic b);
        int exp_y;
        @(negedge proc_clk);
        reset    = r;
        can_jump = c;
        jump_btn = b;
        @(posedge proc_clk);
        model_step(r, c, b);
        #1;
        exp_y = (m_pos >= 0) ? traj[m_pos] : 0;
        chk("y_offset",    32'(y_offset),    32'(exp_y));
        chk("jumping",     32'(jumping),     32'(m_pos >= 0));
        chk("busy",        32'(busy),        32'(m_pos >= 0 || m_wait >= 0));
        chk("jump_start",  32'(jump_start),  32'(m_start));
        chk("jump_done",   32'(jump_done),   32'(m_done));
        chk("req_dropped", 32'(req_dropped), 32'(m_drop));
    endtask

    task automatic settle();
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    int starts;
    int dones;
    logic rb, rc, rr;

    initial begin
        reset    = 1'b1;
        can_jump = 1'b0;
        jump_btn = 1'b0;
        build_traj();
        m_pos = -1; m_wait = -1; m_prev = 0; m_buf = 0;
        m_start = 0; m_done = 0; m_drop = 0;

        // Reset for three cycles: every output must read zero.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("reset_y",    32'(y_offset), 32'd0);
        chk("reset_busy", 32'(busy),     32'd0);

        // Plain jump with the window open.
        for (int i = 1; i <= 22; i++) begin
            cycle(1'b0, 1'b1, (i == 1));
            if (i == 1)  chk("a_start",  32'(jump_start), 32'd1);
            if (i == 2)  chk("a_y4",     32'(y_offset),   32'd4);
            if (i == 9)  chk("a_peak",   32'(y_offset),   32'd32);
            if (i == 12) chk("a_hold",   32'(y_offset),   32'd32);
            if (i == 14) chk("a_fall",   32'(y_offset),   32'd28);
            if (i == 21) begin
                chk("a_land_y",    32'(y_offset), 32'd0);
                chk("a_land_done", 32'(jump_done), 32'd1);
                chk("a_land_jmp",  32'(jumping),   32'd0);
            end
        end
        settle();

        // Press without a window: request times out.
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b0, (i == 1));
            if (i == 1)  chk("b_busy",    32'(busy),        32'd1);
            if (i == 16) chk("b_nodrop",  32'(req_dropped), 32'd0);
            if (i == 17) chk("b_dropped", 32'(req_dropped), 32'd1);
            if (i == 18) chk("b_idle",    32'(busy),        32'd0);
        end
        settle();

        // Press without a window, window opens a few cycles later.
        for (int i = 1; i <= 24; i++) begin
            cycle(1'b0, (i == 6), (i == 1));
            if (i == 6)  chk("c_start", 32'(jump_start), 32'd1);
            if (i == 14) chk("c_peak",  32'(y_offset),   32'd32);
        end
        settle();

        // Button held for 40 cycles: one jump only; a fresh press jumps again.
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            if (jump_start) starts++;
        end
        chk("d_one_start", 32'(starts), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("d_second_start", 32'(jump_start), 32'd1);
        settle();

        // Reset in the middle of the rise.
        dones = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle((i == 7), 1'b1, (i == 1));
            if (jump_done) dones++;
            if (i == 6) chk("e_y20",   32'(y_offset), 32'd20);
            if (i == 7) begin
                chk("e_y0",   32'(y_offset), 32'd0);
                chk("e_idle", 32'(busy),     32'd0);
            end
        end
        chk("e_no_done", 32'(dones), 32'd0);
        settle();

        // Press during the fall with a window open on the landing cycle.
        for (int i = 1; i <= 24; i++) begin
            cycle(1'b0, (i == 1 || i == 21), (i == 1 || i == 16));
            if (i == 21) begin
                chk("f_done", 32'(jump_done), 32'd1);
`ifdef JUMP_BUFFER_EN
                chk("f_start", 32'(jump_start), 32'd1);
`else
                chk("f_start", 32'(jump_start), 32'd0);
                chk("f_idle",  32'(busy),       32'd0);
`endif
            end
        end
        settle();

        // Randomized traffic against the model.
        rb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            rc = ($urandom_range(0, 5) == 0);
            rr = ($urandom_range(0, 399) == 0);
            cycle(rr, rc, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
